// File: rtl/core88_membridge.sv
// Byte-bus to 16-bit asynchronous SRAM bridge for the core88 CPU.
// A one-word write-through read buffer lets the second byte of a word be served without another SRAM access.
module core88_membridge #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [19:0] address,
  input  logic [7:0]  data,
  input  logic        wreq,
  output logic [7:0]  bus,
  output logic        locked,
  input  logic        flush,
  output logic [18:0] sram_addr,
  input  logic [15:0] sram_din,
  output logic [15:0] sram_dout,
  output logic [1:0]  sram_be,
  output logic        sram_oe,
  output logic        sram_we
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WDONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] buf_word_q, buf_word_d;
  logic [18:0] buf_tag_q, buf_tag_d;
  logic        buf_valid_q, buf_valid_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] dout_q, dout_d;
  logic        hit;

  assign hit = buf_valid_q && (buf_tag_q == address[19:1]);

  // NOTE: reset is sampled on the clock edge only; a reset in READ/WRITE drops the strobes on that same edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      buf_word_q  <= '0;
      buf_tag_q   <= '0;
      buf_valid_q <= 1'b0;
      cnt_q       <= '0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      buf_word_q  <= buf_word_d;
      buf_tag_q   <= buf_tag_d;
      buf_valid_q <= buf_valid_d;
      cnt_q       <= cnt_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      be_q        <= be_d;
      dout_q      <= dout_d;
    end
  end

  // NOTE: every next-state variable takes its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    buf_word_d  = buf_word_q;
    buf_tag_d   = buf_tag_q;
    buf_valid_d = buf_valid_q;
    cnt_d       = cnt_q;
    oe_d        = oe_q;
    we_d        = we_q;
    be_d        = be_q;
    dout_d      = dout_q;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          buf_valid_d = 1'b0;
        end else if (wreq) begin
          state_d = WRITE;
          cnt_d   = CNT_INIT;
          be_d    = address[0] ? 2'b10 : 2'b01;
          dout_d  = {data, data};
          we_d    = 1'b1;
        end else if (!hit) begin
          state_d = READ;
          cnt_d   = CNT_INIT;
          oe_d    = 1'b1;
        end
      end
      READ: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          buf_word_d  = sram_din;
          buf_tag_d   = address[19:1];
          buf_valid_d = !flush;
          oe_d        = 1'b0;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          we_d    = 1'b0;
          be_d    = 2'b00;
          state_d = WDONE;
          // Keep the buffer coherent with the byte just committed to SRAM.
          if (flush) begin
            buf_valid_d = 1'b0;
          end else if (hit) begin
            if (address[0]) buf_word_d[15:8] = data;
            else            buf_word_d[7:0]  = data;
          end
        end
      end
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    locked    = resetn && (((state_q == IDLE) && hit && !wreq && !flush) || (state_q == WDONE));
    bus       = address[0] ? buf_word_q[15:8] : buf_word_q[7:0];
    sram_addr = address[19:1];
    sram_oe   = oe_q;
    sram_we   = we_q;
    sram_be   = be_q;
    sram_dout = dout_q;
  end

endmodule

// File: tb/tb_core88_membridge.sv
// Directed bench for core88_membridge: one instance with WAIT_CYCLES=2 and one with WAIT_CYCLES=1,
// each backed by its own small SRAM model; sel chooses which instance is observed.
module tb_core88_membridge;

  logic        clock = 1'b0;
  logic        resetn;
  logic [19:0] address;
  logic [7:0]  data;
  logic        wreq;
  logic        flush;
  logic        sel;

  logic [7:0]  bus0, bus1;
  logic        locked0, locked1;
  logic [18:0] saddr0, saddr1;
  logic [15:0] din0, din1, dout0, dout1;
  logic [1:0]  be0, be1;
  logic        oe0, oe1, we0, we1;

  logic [15:0] mem0 [0:511];
  logic [15:0] mem1 [0:511];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  core88_membridge #(.WAIT_CYCLES(2)) dut0 (
    .clock(clock), .resetn(resetn), .address(address), .data(data), .wreq(wreq),
    .bus(bus0), .locked(locked0), .flush(flush), .sram_addr(saddr0), .sram_din(din0),
    .sram_dout(dout0), .sram_be(be0), .sram_oe(oe0), .sram_we(we0)
  );

  core88_membridge #(.WAIT_CYCLES(1)) dut1 (
    .clock(clock), .resetn(resetn), .address(address), .data(data), .wreq(wreq),
    .bus(bus1), .locked(locked1), .flush(flush), .sram_addr(saddr1), .sram_din(din1),
    .sram_dout(dout1), .sram_be(be1), .sram_oe(oe1), .sram_we(we1)
  );

  function automatic logic [8:0] idx(input logic [18:0] a);
    return {a[16], a[7:0]};
  endfunction

  assign din0 = mem0[idx(saddr0)];
  assign din1 = mem1[idx(saddr1)];

  // SRAM models: preload known words while reset is held, byte-lane writes otherwise.
  always @(posedge clock) begin
    if (!resetn) begin
      mem0[9'h008] <= 16'hBEEF;
      mem0[9'h020] <= 16'h1234;
      mem1[9'h008] <= 16'hBEEF;
    end else begin
      if (we0 && be0[0]) mem0[idx(saddr0)][7:0]  <= dout0[7:0];
      if (we0 && be0[1]) mem0[idx(saddr0)][15:8] <= dout0[15:8];
      if (we1 && be1[0]) mem1[idx(saddr1)][7:0]  <= dout1[7:0];
      if (we1 && be1[1]) mem1[idx(saddr1)][15:8] <= dout1[15:8];
    end
  end

  logic [7:0]  bus_m;
  logic        lk_m, oe_m, we_m;
  logic [1:0]  be_m;
  logic [15:0] dout_m;
  logic [18:0] saddr_m;

  assign bus_m   = sel ? bus1    : bus0;
  assign lk_m    = sel ? locked1 : locked0;
  assign oe_m    = sel ? oe1     : oe0;
  assign we_m    = sel ? we1     : we0;
  assign be_m    = sel ? be1     : be0;
  assign dout_m  = sel ? dout1   : dout0;
  assign saddr_m = sel ? saddr1  : saddr0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [19:0] a, input logic [7:0] exp_bus,
                         input int exp_stall, input int exp_oe, input string name);
    int stall = 0;
    int oes = 0;
    address = a; wreq = 1'b0; flush = 1'b0;
    #1;
    while (!lk_m && stall < 20) begin
      if (oe_m) oes++;
      stall++;
      tick();
    end
    checks++;
    if (stall !== exp_stall) begin
      errors++; $display("FAIL %s stall: got %0d expected %0d", name, stall, exp_stall);
    end
    checks++;
    if (oes !== exp_oe) begin
      errors++; $display("FAIL %s oe_cycles: got %0d expected %0d", name, oes, exp_oe);
    end
    checks++;
    if (bus_m !== exp_bus || oe_m !== 1'b0) begin
      errors++; $display("FAIL %s bus/oe: got %h/%b expected %h/0", name, bus_m, oe_m, exp_bus);
    end
    tick();
  endtask

  task automatic do_write(input logic [19:0] a, input logic [7:0] d, input logic [1:0] exp_be,
                          input logic [15:0] exp_dout, input logic [18:0] exp_addr,
                          input int exp_stall, input int exp_we, input string name);
    int stall = 0;
    int wes = 0;
    address = a; data = d; wreq = 1'b1; flush = 1'b0;
    #1;
    while (!lk_m && stall < 20) begin
      if (we_m) begin
        if (wes == 0) begin
          checks++;
          if (be_m !== exp_be || dout_m !== exp_dout || saddr_m !== exp_addr) begin
            errors++;
            $display("FAIL %s strobe: got be=%b dout=%h addr=%h expected be=%b dout=%h addr=%h",
                     name, be_m, dout_m, saddr_m, exp_be, exp_dout, exp_addr);
          end
        end
        wes++;
      end
      stall++;
      tick();
    end
    checks++;
    if (stall !== exp_stall || wes !== exp_we) begin
      errors++; $display("FAIL %s timing: got stall=%0d we=%0d expected stall=%0d we=%0d",
                         name, stall, wes, exp_stall, exp_we);
    end
    checks++;
    if (we_m !== 1'b0 || be_m !== 2'b00) begin
      errors++; $display("FAIL %s wdone: got we=%b be=%b expected 0/00", name, we_m, be_m);
    end
    tick();
    wreq = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; wreq = 1'b0; flush = 1'b0; data = 8'h00; address = 20'h00010;
    tick();
    tick();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    apply_reset();
    checks++;
    if (oe0 !== 1'b0 || we0 !== 1'b0 || be0 !== 2'b00 || dout0 !== 16'h0000 || locked0 !== 1'b0) begin
      errors++; $display("FAIL reset: got oe=%b we=%b be=%b dout=%h locked=%b expected all 0",
                         oe0, we0, be0, dout0, locked0);
    end
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_read_miss();
    do_read(20'h00010, 8'hEF, 3, 2, "read_miss");
    do_read(20'h00011, 8'hBE, 0, 0, "read_hit_odd");
  endtask

  task automatic test_write_through();
    do_write(20'h00011, 8'h5A, 2'b10, 16'h5A5A, 19'h00008, 3, 2, "write_hit");
    do_read(20'h00011, 8'h5A, 0, 0, "wt_read_hi");
    do_read(20'h00010, 8'hEF, 0, 0, "wt_read_lo");
  endtask

  task automatic test_write_miss();
    do_write(20'h20000, 8'h33, 2'b01, 16'h3333, 19'h10000, 3, 2, "write_miss");
    do_read(20'h00010, 8'hEF, 0, 0, "wm_read");
  endtask

  task automatic test_flush();
    address = 20'h00010; flush = 1'b1;
    #1;
    checks++;
    if (locked0 !== 1'b0) begin
      errors++; $display("FAIL flush_locked: got %b expected 0", locked0);
    end
    tick();
    flush = 1'b0;
    do_read(20'h00010, 8'hEF, 3, 2, "flush_refetch");
  endtask

  task automatic test_back_to_back();
    do_write(20'h00011, 8'h77, 2'b10, 16'h7777, 19'h00008, 3, 2, "b2b_first");
    do_write(20'h00011, 8'h77, 2'b10, 16'h7777, 19'h00008, 3, 2, "b2b_second");
    do_read(20'h00011, 8'h77, 0, 0, "b2b_read");
  endtask

  task automatic test_reset_mid_read();
    address = 20'h00040; wreq = 1'b0; flush = 1'b0;
    tick();
    checks++;
    if (oe0 !== 1'b1) begin
      errors++; $display("FAIL mid_read_oe: got %b expected 1", oe0);
    end
    tick();
    resetn = 1'b0;
    #1;
    checks++;
    if (locked0 !== 1'b0) begin
      errors++; $display("FAIL mid_read_locked: got %b expected 0", locked0);
    end
    tick();
    checks++;
    if (oe0 !== 1'b0) begin
      errors++; $display("FAIL mid_read_abort: got oe=%b expected 0", oe0);
    end
    resetn = 1'b1;
    address = 20'h00010;
    #1;
    checks++;
    if (locked0 !== 1'b0) begin
      errors++; $display("FAIL mid_read_invalid: got locked=%b expected 0", locked0);
    end
    do_read(20'h00040, 8'h34, 3, 2, "mid_read_refetch");
  endtask

  task automatic test_wait_one();
    sel = 1'b1;
    apply_reset();
    resetn = 1'b1;
    do_read(20'h00010, 8'hEF, 2, 1, "w1_read_miss");
    do_write(20'h00000, 8'h11, 2'b01, 16'h1111, 19'h00000, 2, 1, "w1_write_even");
    do_write(20'h00001, 8'h22, 2'b10, 16'h2222, 19'h00000, 2, 1, "w1_write_odd");
    checks++;
    if (mem1[9'h000] !== 16'h2211) begin
      errors++; $display("FAIL w1_mem: got %h expected 2211", mem1[9'h000]);
    end
  endtask

  initial begin
    sel = 1'b0; resetn = 1'b0; address = '0; data = '0; wreq = 1'b0; flush = 1'b0;
    test_reset();
    test_read_miss();
    test_write_through();
    test_write_miss();
    test_flush();
    test_back_to_back();
    test_reset_mid_read();
    test_wait_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core88_membridge.md
Name: core88_membridge

Overview:
- Memory-side neighbour of the core88 CPU. It serves the core's combinational byte bus (20-bit address, 8-bit read/write, `wreq`) from an external 16-bit asynchronous SRAM that needs multi-cycle accesses.
- It stalls the core by deasserting `locked` until the addressed byte is valid on `bus`, or until a write has been committed.
- A one-word read buffer with write-through lets sequential fetches of the two bytes in a word complete without a second SRAM access.

Parameters:
- WAIT_CYCLES, 2, SRAM strobe length in clocks for both read and write (legal range 1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- address  in  20  core byte address (combinational from core registers).
- data  in  8  core write byte.
- wreq  in  1  core write request; held with `address` and `data` while `locked`=0.
- bus  out  8  read byte to core (combinational from buffer).
- locked  out  1  core advance enable (combinational from state and `address`).
- flush  in  1  invalidate read buffer (video/DMA coherence).
- sram_addr  out  19  word address, equal to `address[19:1]` while accessing.
- sram_din  in  16  SRAM read data.
- sram_dout  out  16  SRAM write data.
- sram_be  out  2  byte enables; bit0 = low byte (even address).
- sram_oe  out  1  read strobe.
- sram_we  out  1  write strobe.

Behaviour:
- State: `buf_word[15:0]`, `buf_tag[18:0]`, `buf_valid`, `cnt[3:0]`, and an FSM with states IDLE, READ, WRITE, WDONE.
- Reset (`resetn`=0 at a clock edge):
  - FSM goes to IDLE; `buf_valid`=0; `buf_word`=0; `buf_tag`=0; `cnt`=0.
  - `sram_oe`=0, `sram_we`=0, `sram_be`=0, `sram_dout`=0.
  - `locked` reads 0 during reset regardless of `address`.
  - Reset during READ or WRITE aborts the access immediately; strobes drop on the same edge.
- hit = `buf_valid` & (`buf_tag` == `address[19:1]`).
- `bus` = `address[0]` ? `buf_word[15:8]` : `buf_word[7:0]`, in every state.
- `locked` = (IDLE & hit & !`wreq` & !`flush`) | WDONE.
- IDLE transitions, in priority order:
  - `flush`=1: `buf_valid` <= 0, stay in IDLE. `flush` has priority over everything else in IDLE.
  - else `wreq`=1: go to WRITE with `cnt` <= WAIT_CYCLES-1.
    - `sram_be` <= `address[0]` ? 2'b10 : 2'b01.
    - `sram_dout` <= {`data`, `data`}.
    - `sram_we` <= 1.
  - else !hit: go to READ with `cnt` <= WAIT_CYCLES-1 and `sram_oe` <= 1.
  - else: hit, the core consumes `bus` this cycle, stay in IDLE.
- `sram_addr` = `address[19:1]` combinationally. The core holds `address` stable while `locked`=0.
- READ:
  - While `cnt`≠0: decrement `cnt`.
  - When `cnt`=0:
    - `buf_word` <= `sram_din`, `buf_tag` <= `address[19:1]`.
    - `buf_valid` <= !`flush` (a flush during a read discards the word).
    - `sram_oe` <= 0, go to IDLE.
  - Read-miss stall is WAIT_CYCLES+1 cycles of `locked`=0, followed by the hit cycle.
- WRITE:
  - While `cnt`≠0: decrement `cnt`.
  - When `cnt`=0: `sram_we` <= 0, `sram_be` <= 0, go to WDONE.
  - On that same edge, write-through: if hit and !`flush`, update the addressed byte lane of `buf_word` with `data`. A flush clears `buf_valid` instead.
- WDONE:
  - `locked`=1 for exactly one cycle; the core retires the write byte.
  - Unconditionally go to IDLE. Back-to-back writes to the same address are therefore two separate SRAM writes.
- Timing:
  - Write latency is WAIT_CYCLES+1 stall cycles plus the WDONE cycle.
  - A hit read costs 1 cycle.
- No combinational path from `locked` back to `address`; the core address comes from registers.

Test Plan:
- Read miss, WAIT_CYCLES=2:
  - Stimulus: reset, then `address`=0x00010; SRAM word 0x0008 = 0xBEEF.
  - Required: `sram_oe` high for 2 cycles; `locked`=0 for 3 cycles, then `locked`=1 with `bus`=0xEF.
  - Then `address`=0x00011: `locked`=1 on the same cycle, `bus`=0xBE, and no new `sram_oe`.
- Write-through hit:
  - Stimulus: buffer holds word 0x0008 = 0xBEEF; write `data`=0x5A to `address`=0x00011.
  - Required: `sram_be`=2'b10, `sram_dout`=0x5A5A, `sram_we` high 2 cycles, WDONE `locked` pulse.
  - Then reading 0x00011 hits with `bus`=0x5A.
- Write miss:
  - Stimulus: write 0x33 to 0x20000 while the buffer holds word 0x0008.
  - Required: `sram_be`=2'b01, `sram_addr`=0x10000; `buf_word` unchanged; a later read of 0x00010 still hits 0xEF.
- Flush:
  - Stimulus: assert `flush` one cycle in IDLE, with the buffer valid for 0x00010.
  - Required: `locked`=0 that cycle; the next read of 0x00010 performs a fresh `sram_oe` access.
- Reset mid-read:
  - Stimulus: drop `resetn` on the 2nd cycle of READ.
  - Required: `sram_oe`=0 after the edge, `buf_valid`=0; after release, a read of the same address re-fetches from SRAM.
- WAIT_CYCLES=1 boundary:
  - Required: the read-miss strobe lasts 1 cycle and the stall is 2 cycles.
  - Consecutive writes to 0x00000 and 0x00001 each produce one `sram_we` pulse and one WDONE.
